// File: rtl/alu_issue_unit.sv
// Request FIFO plus IDLE/EXEC/DONE sequencer around a combinational 8-bit ALU.
// Operands are registered into the ALU, and the result is held in a response register until it is accepted.
module alu_issue_unit #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 3,
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic [OP_W-1:0]   req_opcode,
   input  logic [TAG_W-1:0]  req_tag,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_opcode,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [4:0]        alu_flags,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic [4:0]        rsp_flags,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic [CNT_W-1:0]  op_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [OP_W-1:0]   op;
      logic [TAG_W-1:0]  tag;
   } req_t;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   req_t             mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             empty, full;
   logic             push, pop, capture, complete;
   logic [TAG_W-1:0] cur_tag;
   req_t             head;
   state_t           state, state_nxt;

   assign empty     = (count == '0);
   assign full      = (count == (AW+1)'(DEPTH));
   assign req_ready = !full && !flush;
   assign push      = req_valid && req_ready;
   assign head      = mem[rd_ptr];

   // Flush overrides everything: no pop, no capture, and a pending handshake is dropped
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      capture   = 1'b0;
      complete  = 1'b0;
      case (state)
         IDLE: if (!empty) begin
            pop       = 1'b1;
            state_nxt = EXEC;
         end
         EXEC: begin
            capture   = 1'b1;
            state_nxt = DONE;
         end
         DONE: if (rsp_ready) begin
            complete = 1'b1;
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = EXEC;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) begin
         state_nxt = IDLE;
         pop       = 1'b0;
         capture   = 1'b0;
         complete  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Storage needs no reset; occupancy is tracked by the pointers and the count
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{a: req_a, b: req_b, op: req_opcode, tag: req_tag};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         cur_tag    <= '0;
      end else if (pop) begin
         alu_a      <= head.a;
         alu_b      <= head.b;
         alu_opcode <= head.op;
         cur_tag    <= head.tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         rsp_tag    <= '0;
         op_count   <= '0;
      end else begin
         if (flush) begin
            rsp_valid <= 1'b0;
         end else if (capture) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_out;
            rsp_flags  <= alu_flags;
            rsp_tag    <= cur_tag;
         end else if (complete) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit with a behavioural 8-bit ALU on the alu_* side.
module tb_alu_issue_unit;

   logic       clk = 1'b0;
   logic       rst_n, flush, req_valid, req_ready, rsp_valid, rsp_ready;
   logic [7:0] req_a, req_b, alu_a, alu_b, alu_out, rsp_result;
   logic [2:0] req_opcode, alu_opcode;
   logic [3:0] req_tag, rsp_tag;
   logic [4:0] alu_flags, rsp_flags;
   logic [15:0] op_count;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [7:0] res;
      logic [4:0] flg;
      logic [3:0] tag;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_issue_unit dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode), .req_tag(req_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_out(alu_out), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
      .op_count(op_count)
   );

   // Reference ALU: returns {overflow,parity,carry,zero,sign, result}
   function automatic logic [12:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op);
      logic [8:0] r9;
      logic       ov;
      ov = 1'b0;
      case (op)
         3'd0: begin r9 = {1'b0, a} + {1'b0, b}; ov = (a[7] == b[7]) && (r9[7] != a[7]); end
         3'd1: begin r9 = {1'b0, a} - {1'b0, b}; ov = (a[7] != b[7]) && (r9[7] != a[7]); end
         3'd2: r9 = {1'b0, a & b};
         3'd3: r9 = {1'b0, a | b};
         3'd4: r9 = {1'b0, a ^ b};
         3'd5: r9 = {1'b0, ~a};
         3'd6: r9 = {a, 1'b0};
         default: r9 = {a[0], 1'b0, a[7:1]};
      endcase
      return {ov, ^r9[7:0], r9[8], r9[7:0] == 8'd0, r9[7], r9[7:0]};
   endfunction

   assign {alu_flags, alu_out} = alu_model(alu_a, alu_b, alu_opcode);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Handshake is taken at the next posedge; sample it half a cycle earlier
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) chk("unexpected_rsp", 32'(rsp_tag), 32'hFFFF);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_result", 32'(rsp_result), 32'(e.res));
            chk("rsp_flags", 32'(rsp_flags), 32'(e.flg));
            chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
         end
      end
   end

   function automatic exp_t mk_exp(input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] op, input logic [3:0] t);
      logic [12:0] m;
      m = alu_model(a, b, op);
      return '{res: m[7:0], flg: m[12:8], tag: t};
   endfunction

   task automatic push(input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [3:0] t);
      bit ok;
      ok = 1'b0;
      req_valid = 1'b1; req_a = a; req_b = b; req_opcode = op; req_tag = t;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            sb.push_back(mk_exp(a, b, op, t));
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      if (!ok) chk("push_timeout", 0, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", 32'(sb.size()), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int acc;
      logic [7:0] s_res;
      logic [4:0] s_flg;
      logic [3:0] s_tag;
      flush = 0; req_valid = 0; rsp_ready = 0;
      req_a = 0; req_b = 0; req_opcode = 0; req_tag = 0;

      // 1: async reset without a clock edge
      rst_n = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 1);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_alu_a", 32'(alu_a), 0);
      chk("rst_op_count", 32'(op_count), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 2: all opcodes, in-order tags
      rsp_ready = 1'b1;
      for (int k = 0; k < 8; k++) push(8'd5, 8'd11, 3'(k), 4'(k));
      drain();
      chk("op_count_8", 32'(op_count), 8);

      // 3: latency
      req_valid = 1'b1; req_a = 8'd5; req_b = 8'd11; req_opcode = 3'd0; req_tag = 4'd9;
      sb.push_back(mk_exp(8'd5, 8'd11, 3'd0, 4'd9));
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("lat_alu_a_n", 32'(rsp_valid), 0);
      @(posedge clk); #1;
      chk("lat_alu_a", 32'(alu_a), 5);
      chk("lat_rsp_early", 32'(rsp_valid), 0);
      @(posedge clk); #1;
      chk("lat_rsp_valid", 32'(rsp_valid), 1);
      drain();
      chk("op_count_9", 32'(op_count), 9);

      // 4: backpressure, capacity and hold stability
      rsp_ready = 1'b0;
      acc = 0;
      req_valid = 1'b1; req_b = 8'd3; req_opcode = 3'd0;
      for (int k = 0; k < 8; k++) begin
         req_a = 8'(acc + 1); req_tag = 4'(acc);
         @(negedge clk);
         if (req_ready) begin
            sb.push_back(mk_exp(req_a, req_b, req_opcode, req_tag));
            acc++;
         end
         @(posedge clk); #1;
      end
      chk("cap_accepted", 32'(acc), 5);
      chk("cap_ready_low", 32'(req_ready), 0);
      s_res = rsp_result; s_flg = rsp_flags; s_tag = rsp_tag;
      chk("hold_valid", 32'(rsp_valid), 1);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         chk("hold_stable", {rsp_valid, s_res ^ rsp_result, s_flg ^ rsp_flags, s_tag ^ rsp_tag}, {1'b1, 8'd0, 5'd0, 4'd0});
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      drain();
      chk("op_count_14", 32'(op_count), 14);

      // 5: flush in DONE with three queued
      rsp_ready = 1'b0;
      for (int k = 0; k < 4; k++) push(8'(k), 8'd1, 3'd2, 4'(k));
      repeat (3) @(posedge clk); #1;
      chk("fl_pre_valid", 32'(rsp_valid), 1);
      flush = 1'b1; req_valid = 1'b1; req_a = 8'hAA; req_tag = 4'hE;
      #1;
      chk("fl_ready", 32'(req_ready), 0);
      @(posedge clk); #1;
      flush = 1'b0; req_valid = 1'b0;
      sb.delete();
      chk("fl_rsp_valid", 32'(rsp_valid), 0);
      chk("fl_op_count", 32'(op_count), 14);
      repeat (5) @(posedge clk); #1;
      chk("fl_empty", 32'(rsp_valid), 0);
      rsp_ready = 1'b1;
      push(8'd7, 8'd9, 3'd4, 4'd6);
      drain();
      chk("op_count_15", 32'(op_count), 15);

      // 6: reset during EXEC
      rsp_ready = 1'b0;
      push(8'd8, 8'd2, 3'd1, 4'd3);
      push(8'd1, 8'd2, 3'd3, 4'd4);
      chk("rst_exec_alu_a", 32'(alu_a), 8);
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("rst2_rsp_valid", 32'(rsp_valid), 0);
      chk("rst2_op_count", 32'(op_count), 0);
      chk("rst2_alu", {alu_a, alu_b, 5'd0, alu_opcode}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         chk("rst2_no_stale", 32'(rsp_valid), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
